bcd2bin32: RTL and testbench
============================

// Module: bcd2bin32
// PURPOSE
//  Iterative BCD-to-binary converter; inverse of the 8-digit bin2bcd32 display path.
//  Converts 8 packed BCD digits (e.g. keypad/operand entry) into a 32-bit unsigned value for the FACT accelerator.
//  Uses a start/done handshake and processes one digit per clock by Horner multiply-by-10 accumulate.
// PARAMETERS
//  NDIG   8   number of BCD digits; dig0 = least significant
//  OUT_W  32  result width; must be >= 27 for NDIG=8 (max 99,999,999 = 0x05F5E0FF)
// PORTS
//  clk    in   1      rising-edge clock, single clock domain
//  rst_n  in   1      asynchronous active-low reset
//  start  in   1      request conversion; sampled only when busy=0
//  dig0   in   4      BCD digit 10^0
//  dig1   in   4      BCD digit 10^1
//  dig2   in   4      BCD digit 10^2
//  dig3   in   4      BCD digit 10^3
//  dig4   in   4      BCD digit 10^4
//  dig5   in   4      BCD digit 10^5
//  dig6   in   4      BCD digit 10^6
//  dig7   in   4      BCD digit 10^7
//  busy   out  1      conversion in progress
//  done   out  1      one-cycle pulse: value/err valid and updated
//  value  out  OUT_W  binary result; holds until next done
//  err    out  1      last conversion saw a digit > 9; holds until next done
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; busy=0, done=0, err=0, value=0; accumulator, index and digit latch cleared.
//  States: IDLE, CONV. No other states; encoding is a 1-bit enum.
//  IDLE: start=1 at edge E0 -> latch all NDIG digits; acc=0; idx=NDIG-1; bad = OR(dig_i > 9); -> CONV, busy=1.
//  CONV: each edge acc <= acc*10 + dig[idx]; idx decrements.
//   - acc*10 is computed as (acc<<3)+(acc<<1), truncated to OUT_W (wraps mod 2^OUT_W if OUT_W is undersized).
//  Completion: at edge E(NDIG), after dig0 is accumulated -> IDLE, busy=0, done=1.
//   - value <= bad ? 0 : acc_next; err <= bad.
//  Latency: done is high in the cycle following edge E(NDIG), i.e. exactly NDIG clocks after start is sampled. Fixed; independent of data and error.
//  done: high for exactly one cycle, cleared at the next edge.
//  start while busy=1 (including the completion edge): ignored, not queued; latched digits are unaffected by input changes.
//  start in the cycle where done=1 (state IDLE): accepted. Back-to-back throughput is one conversion per NDIG+1 clocks.
//  Digit inputs are sampled only at the accepting edge and need not be held afterwards.
//  Reset mid-conversion: immediate abort to reset values; no done is produced.
// STRUCTURE
//  Package bcd2bin_pkg: typedef state_t {IDLE, CONV}; localparams NDIG_DEF=8, OUT_W_DEF=32, BCD_MAX=4'd9.
//  Sub-module bcd_mac10: combinational acc_out = acc_in*10 + d (shift-add, OUT_W wide).
//   - FSM, index counter, digit latch and output registers stay in bcd2bin32.
// TESTING
//  T1: digits 1,2,3,4,5,6,7,8 (dig7..dig0), start 1 cycle -> after 8 clks done=1, value=0x00BC614E, err=0.
//  T2: all digits 9 -> value=0x05F5E0FF, err=0; all digits 0 -> value=0, err=0, done still at +8.
//  T3: dig3=4'hA, others 1 -> done at +8, value=0, err=1; next valid conversion clears err.
//  T4: start held high continuously with changing digits -> conversions every 9 clks, each on digits at its accepting edge.
//  T5: pulse start at +3 during busy -> ignored; single done at +8 with first operand.
//  T6: assert rst_n=0 at +4 -> outputs 0 immediately, no done; new start after release converts correctly.

Source files
------------

// File: rtl/bcd2bin32_pkg.sv
// ----------------------------------------------------------------------------
// bcd2bin_pkg
// Shared types and constants for the iterative BCD-to-binary converter.
//   state_t   : controller states (IDLE waits for start, CONV accumulates)
//   NDIG_DEF  : default number of BCD digits
//   OUT_W_DEF : default binary result width
//   BCD_MAX   : largest legal BCD digit value
// ----------------------------------------------------------------------------
package bcd2bin_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    localparam int       NDIG_DEF  = 8;
    localparam int       OUT_W_DEF = 32;
    localparam bit [3:0] BCD_MAX   = 4'd9;

endpackage

// File: rtl/bcd2bin32_if.sv
// ----------------------------------------------------------------------------
// bcd2bin32_if
// Start/done handshake bundle between a requester and the bcd2bin32 converter.
//   start      : request a conversion (requester -> converter)
//   dig0..dig7 : packed BCD operand, dig0 = 10^0 (requester -> converter)
//   busy       : conversion in progress (converter -> requester)
//   done       : one-cycle pulse, value/err just updated (converter -> requester)
//   value      : binary result, held until the next done
//   err        : last conversion saw a non-BCD digit, held until the next done
// Modports: master = requester side, slave = converter side.
// ----------------------------------------------------------------------------
interface bcd2bin32_if
    import bcd2bin_pkg::*;
#(
    parameter int OUT_W = OUT_W_DEF
) ();

    logic             start;
    logic [3:0]       dig0;
    logic [3:0]       dig1;
    logic [3:0]       dig2;
    logic [3:0]       dig3;
    logic [3:0]       dig4;
    logic [3:0]       dig5;
    logic [3:0]       dig6;
    logic [3:0]       dig7;
    logic             busy;
    logic             done;
    logic [OUT_W-1:0] value;
    logic             err;

    modport master (
        output start, dig0, dig1, dig2, dig3, dig4, dig5, dig6, dig7,
        input  busy, done, value, err
    );

    modport slave (
        input  start, dig0, dig1, dig2, dig3, dig4, dig5, dig6, dig7,
        output busy, done, value, err
    );

endinterface

// File: rtl/bcd2bin32_mac10.sv
// ----------------------------------------------------------------------------
// bcd_mac10
// Combinational Horner step: acc_out = acc_in * 10 + d, OUT_W bits wide.
//   acc_in  : running accumulator
//   d       : next BCD digit (more significant digits arrive first)
//   acc_out : updated accumulator, wraps modulo 2^OUT_W
// ----------------------------------------------------------------------------
module bcd_mac10
    import bcd2bin_pkg::*;
#(
    parameter int OUT_W = OUT_W_DEF
) (
    input  logic [OUT_W-1:0] acc_in,
    input  logic [3:0]       d,
    output logic [OUT_W-1:0] acc_out
);

    // x*10 as x*8 + x*2 keeps this a pair of adders instead of a multiplier.
    assign acc_out = (acc_in << 3) + (acc_in << 1) + OUT_W'(d);

endmodule

// File: rtl/bcd2bin32.sv
// ----------------------------------------------------------------------------
// bcd2bin32
// Iterative BCD-to-binary converter. On an accepted start the NDIG digits are
// latched and folded in one per clock, most significant first, so done pulses
// exactly NDIG clocks after start is sampled. A non-BCD digit forces value=0
// and err=1 for that conversion.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : bcd2bin32_if slave (start, dig0..dig7, busy, done, value, err)
// NDIG may be at most 8 (the interface carries eight digits).
// ----------------------------------------------------------------------------
module bcd2bin32
    import bcd2bin_pkg::*;
#(
    parameter int NDIG  = NDIG_DEF,
    parameter int OUT_W = OUT_W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    bcd2bin32_if.slave   bus
);

    localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;

    logic [3:0]       dig_in  [8];
    logic [3:0]       dig_lat [NDIG];
    logic [IDXW-1:0]  idx;
    logic [OUT_W-1:0] acc;
    logic [OUT_W-1:0] acc_next;
    logic             bad;
    logic             bad_in;
    state_t           state;
    logic             busy_r;
    logic             done_r;
    logic             err_r;
    logic [OUT_W-1:0] value_r;

    assign dig_in[0] = bus.dig0;
    assign dig_in[1] = bus.dig1;
    assign dig_in[2] = bus.dig2;
    assign dig_in[3] = bus.dig3;
    assign dig_in[4] = bus.dig4;
    assign dig_in[5] = bus.dig5;
    assign dig_in[6] = bus.dig6;
    assign dig_in[7] = bus.dig7;

    assign bus.busy  = busy_r;
    assign bus.done  = done_r;
    assign bus.err   = err_r;
    assign bus.value = value_r;

    // The error flag is decided once, from the digits present at the accepting
    // edge, so later input changes cannot affect it.
    always_comb begin
        bad_in = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (dig_in[i] > BCD_MAX) begin
                bad_in = 1'b1;
            end
        end
    end

    bcd_mac10 #(
        .OUT_W (OUT_W)
    ) u_mac (
        .acc_in  (acc),
        .d       (dig_lat[idx]),
        .acc_out (acc_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
            value_r <= '0;
            acc     <= '0;
            idx     <= '0;
            bad     <= 1'b0;
            for (int i = 0; i < NDIG; i++) begin
                dig_lat[i] <= 4'd0;
            end
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        for (int i = 0; i < NDIG; i++) begin
                            dig_lat[i] <= dig_in[i];
                        end
                        acc    <= '0;
                        idx    <= IDXW'(NDIG - 1);
                        bad    <= bad_in;
                        busy_r <= 1'b1;
                        state  <= CONV;
                    end
                end
                CONV: begin
                    acc <= acc_next;
                    // idx==0 means dig0 is being folded in on this edge; start
                    // is not looked at here, so it cannot be queued.
                    if (idx == '0) begin
                        state   <= IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        value_r <= bad ? '0 : acc_next;
                        err_r   <= bad;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd2bin32.sv
// ----------------------------------------------------------------------------
// tb_bcd2bin32
// Directed self-checking bench for bcd2bin32. Digits are written as a 32-bit
// hex word dig7..dig0, so 32'h12345678 means the decimal operand 12345678.
// ----------------------------------------------------------------------------
module tb_bcd2bin32;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    bcd2bin32_if #(.OUT_W(32)) bus ();

    bcd2bin32 #(
        .NDIG  (8),
        .OUT_W (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Hard stop in case something wedges outside the bounded waits.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic set_digits(input logic [31:0] d);
        bus.dig0 = d[3:0];
        bus.dig1 = d[7:4];
        bus.dig2 = d[11:8];
        bus.dig3 = d[15:12];
        bus.dig4 = d[19:16];
        bus.dig5 = d[23:20];
        bus.dig6 = d[27:24];
        bus.dig7 = d[31:28];
    endtask

    // Issue one start pulse, scramble the digit inputs right after the
    // accepting edge, then wait (bounded) for done. lat = -1 on timeout.
    task automatic convert(input logic [31:0] d, output int lat,
                           output logic [31:0] v, output logic e);
        @(negedge clk);
        set_digits(d);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        set_digits(32'h5A5A_5A5A);
        lat = -1;
        v   = 'x;
        e   = 1'bx;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) begin
                lat = c;
                v   = bus.value;
                e   = bus.err;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        bus.start = 1'b0;
        set_digits(32'h0);
        #12;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", bus.done); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", bus.err); end
        checks++; if (bus.value !== 32'h0) begin errors++; $display("[TB] FAIL reset_value: got %h expected 0", bus.value); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_after_reset: busy=%b expected 0", bus.busy); end
    endtask

    task automatic test_basic();
        int          lat;
        logic [31:0] v;
        logic        e;
        convert(32'h1234_5678, lat, v, e);
        checks++; if (lat !== 8) begin errors++; $display("[TB] FAIL basic_latency: got %0d expected 8", lat); end
        checks++; if (v !== 32'h00BC614E) begin errors++; $display("[TB] FAIL basic_value: got %h expected 00bc614e", v); end
        checks++; if (e !== 1'b0) begin errors++; $display("[TB] FAIL basic_err: got %b expected 0", e); end
        @(posedge clk);
        #1;
        checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL done_one_cycle: got %b expected 0", bus.done); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.value !== 32'h00BC614E) begin errors++; $display("[TB] FAIL value_hold: got %h expected 00bc614e", bus.value); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_after_done: busy=%b expected 0", bus.busy); end
    endtask

    task automatic test_extremes();
        logic [31:0] vin  [5] = '{32'h9999_9999, 32'h0000_0000, 32'h8765_4321, 32'h1000_0000, 32'h0000_0042};
        logic [31:0] vexp [5] = '{32'h05F5E0FF, 32'h00000000, 32'h05397FB1, 32'h00989680, 32'h0000002A};
        int          lat;
        logic [31:0] v;
        logic        e;
        for (int k = 0; k < 5; k++) begin
            convert(vin[k], lat, v, e);
            checks++; if (lat !== 8) begin errors++; $display("[TB] FAIL vec%0d_latency: got %0d expected 8", k, lat); end
            checks++; if (v !== vexp[k]) begin errors++; $display("[TB] FAIL vec%0d_value: got %h expected %h", k, v, vexp[k]); end
            checks++; if (e !== 1'b0) begin errors++; $display("[TB] FAIL vec%0d_err: got %b expected 0", k, e); end
        end
    endtask

    task automatic test_bad_digit();
        int          lat;
        logic [31:0] v;
        logic        e;
        convert(32'h1111_A111, lat, v, e);
        checks++; if (lat !== 8) begin errors++; $display("[TB] FAIL bad_latency: got %0d expected 8", lat); end
        checks++; if (v !== 32'h0) begin errors++; $display("[TB] FAIL bad_value: got %h expected 0", v); end
        checks++; if (e !== 1'b1) begin errors++; $display("[TB] FAIL bad_err: got %b expected 1", e); end
        convert(32'hF000_0000, lat, v, e);
        checks++; if (e !== 1'b1 || v !== 32'h0) begin errors++; $display("[TB] FAIL bad_top_digit: got err=%b value=%h expected err=1 value=0", e, v); end
        convert(32'h1111_1111, lat, v, e);
        checks++; if (e !== 1'b0) begin errors++; $display("[TB] FAIL err_clear: got %b expected 0", e); end
        checks++; if (v !== 32'h00A98AC7) begin errors++; $display("[TB] FAIL after_bad_value: got %h expected 00a98ac7", v); end
    endtask

    // start held high: a new conversion is accepted every 9 clocks, each on
    // the digits present at its own accepting edge.
    task automatic test_back_to_back();
        logic [31:0] vin  [3] = '{32'h1234_5678, 32'h8765_4321, 32'h0000_0042};
        logic [31:0] vexp [3] = '{32'h00BC614E, 32'h05397FB1, 32'h0000002A};
        int          extra;
        @(negedge clk);
        set_digits(vin[0]);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            extra = 0;
            for (int c = 1; c <= 9; c++) begin
                @(posedge clk);
                #1;
                if (c == 3) set_digits(32'h9999_9999);
                if (c == 8) begin
                    checks++; if (bus.done !== 1'b1) begin errors++; $display("[TB] FAIL b2b%0d_done: got %b expected 1", k, bus.done); end
                    checks++; if (bus.value !== vexp[k]) begin errors++; $display("[TB] FAIL b2b%0d_value: got %h expected %h", k, bus.value, vexp[k]); end
                    if (k < 2) set_digits(vin[k+1]);
                    else bus.start = 1'b0;
                end else if (bus.done !== 1'b0) begin
                    extra++;
                end
                if (c == 9) begin
                    checks++; if (bus.busy !== (k < 2)) begin errors++; $display("[TB] FAIL b2b%0d_restart: busy=%b expected %b", k, bus.busy, (k < 2)); end
                end
            end
            checks++; if (extra !== 0) begin errors++; $display("[TB] FAIL b2b%0d_stray_done: got %0d expected 0", k, extra); end
        end
    endtask

    task automatic test_ignore_start();
        int          ndone;
        int          first;
        logic [31:0] v;
        ndone = 0;
        first = -1;
        v     = 'x;
        @(negedge clk);
        set_digits(32'h1234_5678);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        set_digits(32'h8765_4321);
        repeat (3) @(posedge clk);
        #1;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int c = 5; c <= 24; c++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) begin
                ndone++;
                if (first < 0) begin
                    first = c;
                    v     = bus.value;
                end
            end
        end
        checks++; if (first !== 8) begin errors++; $display("[TB] FAIL busy_start_latency: got %0d expected 8", first); end
        checks++; if (v !== 32'h00BC614E) begin errors++; $display("[TB] FAIL busy_start_value: got %h expected 00bc614e", v); end
        checks++; if (ndone !== 1) begin errors++; $display("[TB] FAIL busy_start_queued: got %0d dones expected 1", ndone); end
    endtask

    task automatic test_reset_mid();
        int          ndone;
        int          lat;
        logic [31:0] v;
        logic        e;
        @(negedge clk);
        set_digits(32'h1111_1111);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL mid_busy_before: got %b expected 1", bus.busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.value !== 32'h0) begin errors++; $display("[TB] FAIL mid_reset_value: got %h expected 0", bus.value); end
        checks++; if (bus.err !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_flags: err=%b done=%b expected 0 0", bus.err, bus.done); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            if (bus.done !== 1'b0) ndone++;
        end
        checks++; if (ndone !== 0) begin errors++; $display("[TB] FAIL mid_reset_no_done: got %0d expected 0", ndone); end
        convert(32'h8765_4321, lat, v, e);
        checks++; if (lat !== 8 || v !== 32'h05397FB1 || e !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_conv: lat=%0d value=%h err=%b expected 8 05397fb1 0", lat, v, e); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_bad_digit();
        test_back_to_back();
        test_ignore_start();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
